// File: rtl/uart_rx_core.sv
// UART 8N1 receiver with 16x oversampling from the system clock.
// Delivers each good byte as a one-cycle strobe and flags bad stop bits.
module uart_rx_core #(
    parameter int FSYS_CLK   = 50_000_000,
    parameter int BAND_SET   = 115200,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk_50mhz,
    input  logic       rst_n,
    input  logic       uart_rxd,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_frame_err,
    output logic       rx_busy
);

    localparam int         DIV      = FSYS_CLK / (BAND_SET * OVERSAMPLE);
    localparam logic [4:0] DIV_LAST = 5'(DIV - 1);

    // Tick-counter values seen during the sampling tick (tick k has count k-1).
    localparam logic [7:0] START_MID = 8'd7;
    localparam logic [7:0] LAST_BIT  = 8'd135;
    localparam logic [7:0] STOP_MID  = 8'd151;

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

    state_t     state_reg, state_next;
    logic       sync1_reg, sync2_reg;
    logic [4:0] div_cnt_reg, div_cnt_next;
    logic [7:0] tick_cnt_reg, tick_cnt_next;
    logic [7:0] shift_reg, shift_next;
    logic [7:0] rx_data_reg, rx_data_next;
    logic       rx_valid_reg, rx_valid_next;
    logic       rx_frame_err_reg, rx_frame_err_next;
    logic       rx_busy_reg, rx_busy_next;
    logic       rxd_s;
    logic       tick;
    logic       cnt_clear;

    assign rxd_s = sync2_reg;
    assign tick  = (div_cnt_reg == DIV_LAST);

    always_ff @(posedge clk_50mhz or negedge rst_n) begin
        if (!rst_n) begin
            sync1_reg        <= 1'b1;
            sync2_reg        <= 1'b1;
            state_reg        <= IDLE;
            div_cnt_reg      <= '0;
            tick_cnt_reg     <= '0;
            shift_reg        <= '0;
            rx_data_reg      <= '0;
            rx_valid_reg     <= 1'b0;
            rx_frame_err_reg <= 1'b0;
            rx_busy_reg      <= 1'b0;
        end else begin
            sync1_reg        <= uart_rxd;
            sync2_reg        <= sync1_reg;
            state_reg        <= state_next;
            div_cnt_reg      <= div_cnt_next;
            tick_cnt_reg     <= tick_cnt_next;
            shift_reg        <= shift_next;
            rx_data_reg      <= rx_data_next;
            rx_valid_reg     <= rx_valid_next;
            rx_frame_err_reg <= rx_frame_err_next;
            rx_busy_reg      <= rx_busy_next;
        end
    end

    always_comb begin
        state_next        = state_reg;
        shift_next        = shift_reg;
        rx_data_next      = rx_data_reg;
        rx_valid_next     = 1'b0;
        rx_frame_err_next = 1'b0;
        cnt_clear         = 1'b0;

        case (state_reg)
            IDLE: begin
                if (!rxd_s) begin
                    state_next = START;
                    cnt_clear  = 1'b1;
                end
            end
            START: begin
                if (tick && tick_cnt_reg == START_MID)
                    state_next = rxd_s ? IDLE : DATA;
            end
            DATA: begin
                // Every data bit centre falls on a count with low nibble 7.
                if (tick && tick_cnt_reg[3:0] == 4'd7) begin
                    shift_next = {rxd_s, shift_reg[7:1]};
                    if (tick_cnt_reg == LAST_BIT)
                        state_next = STOP;
                end
            end
            STOP: begin
                if (tick && tick_cnt_reg == STOP_MID) begin
                    if (rxd_s) begin
                        rx_data_next  = shift_reg;
                        rx_valid_next = 1'b1;
                        state_next    = IDLE;
                    end else begin
                        rx_frame_err_next = 1'b1;
                        state_next        = WAIT_HIGH;
                    end
                end
            end
            WAIT_HIGH: begin
                if (rxd_s)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase

        if (cnt_clear) begin
            div_cnt_next  = '0;
            tick_cnt_next = '0;
        end else if (tick) begin
            div_cnt_next  = '0;
            tick_cnt_next = tick_cnt_reg + 8'd1;
        end else begin
            div_cnt_next  = div_cnt_reg + 5'd1;
            tick_cnt_next = tick_cnt_reg;
        end

        rx_busy_next = (state_next != IDLE);
    end

    assign rx_data      = rx_data_reg;
    assign rx_valid     = rx_valid_reg;
    assign rx_frame_err = rx_frame_err_reg;
    assign rx_busy      = rx_busy_reg;

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed bench for uart_rx_core: clean frames, rate skew, glitches,
// framing errors with line break, mid-frame reset and strobe latency.
module tb_uart_rx_core;

    logic       clk_50mhz = 1'b0;
    logic       rst_n     = 1'b0;
    logic       uart_rxd  = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_frame_err;
    logic       rx_busy;

    always #10 clk_50mhz = ~clk_50mhz;

    uart_rx_core dut (
        .clk_50mhz    (clk_50mhz),
        .rst_n        (rst_n),
        .uart_rxd     (uart_rxd),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_frame_err (rx_frame_err),
        .rx_busy      (rx_busy)
    );

    int         n_compared   = 0;
    int         n_mismatched = 0;
    int         cyc          = 0;
    int         valid_cnt    = 0;
    int         err_cnt      = 0;
    int         both_cnt     = 0;
    int         start_cyc    = 0;
    int         last_lat     = 0;
    logic       busy_prev    = 1'b0;
    logic [7:0] rx_q[$];

    always @(posedge clk_50mhz) cyc++;

    // Strobe monitor; busy rises the cycle after start detection.
    always @(negedge clk_50mhz) begin
        if (rx_busy === 1'b1 && busy_prev !== 1'b1)
            start_cyc = cyc - 1;
        busy_prev = rx_busy;
        if (rx_valid === 1'b1) begin
            valid_cnt++;
            rx_q.push_back(rx_data);
            last_lat = cyc - start_cyc;
        end
        if (rx_frame_err === 1'b1)
            err_cnt++;
        if (rx_valid === 1'b1 && rx_frame_err === 1'b1)
            both_cnt++;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_compared++;
        if (obs !== exp) begin
            n_mismatched++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end else begin
            $display("ok   %s: %0h", tag, obs);
        end
    endtask

    task automatic drive_bit(input logic v, input int period);
        uart_rxd = v;
        repeat (period) @(negedge clk_50mhz);
    endtask

    task automatic send_frame(input logic [7:0] d, input int period, input logic stop_v);
        drive_bit(1'b0, period);
        for (int i = 0; i < 8; i++)
            drive_bit(d[i], period);
        drive_bit(stop_v, period);
    endtask

    task automatic idle(input int n);
        uart_rxd = 1'b1;
        repeat (n) @(negedge clk_50mhz);
    endtask

    int         v0, e0;
    logic [7:0] exp2 [3];
    logic [7:0] d5;

    initial begin
        exp2[0] = 8'h00;
        exp2[1] = 8'hFF;
        exp2[2] = 8'hA3;
        d5      = 8'hF5;

        rst_n = 1'b0;
        repeat (5) @(negedge clk_50mhz);
        check_eq("reset_rx_data", rx_data, 8'h00);
        check_eq("reset_rx_valid", rx_valid, 1'b0);
        check_eq("reset_frame_err", rx_frame_err, 1'b0);
        check_eq("reset_rx_busy", rx_busy, 1'b0);
        rst_n = 1'b1;
        idle(20);

        // Single frame at nominal rate, plus strobe latency
        v0 = valid_cnt; e0 = err_cnt;
        send_frame(8'h55, 434, 1'b1);
        idle(300);
        check_eq("t1_strobes", valid_cnt - v0, 1);
        check_eq("t1_data", rx_data, 8'h55);
        check_eq("t1_frame_err", err_cnt - e0, 0);
        check_eq("t6_latency", last_lat, 4105);

        // Back-to-back frames with skewed bit periods
        rx_q.delete();
        v0 = valid_cnt;
        send_frame(8'h00, 425, 1'b1);
        send_frame(8'hFF, 443, 1'b1);
        send_frame(8'hA3, 425, 1'b1);
        idle(300);
        check_eq("t2_strobes", valid_cnt - v0, 3);
        for (int i = 0; i < 3; i++)
            check_eq($sformatf("t2_data%0d", i),
                     (i < rx_q.size()) ? {24'h0, rx_q[i]} : 32'hxxxxxxxx, exp2[i]);

        // Short low glitch rejected, then a good frame
        v0 = valid_cnt; e0 = err_cnt;
        uart_rxd = 1'b0;
        repeat (100) @(negedge clk_50mhz);
        idle(300);
        check_eq("t3_glitch_busy", rx_busy, 1'b0);
        check_eq("t3_glitch_strobes", valid_cnt - v0, 0);
        check_eq("t3_glitch_err", err_cnt - e0, 0);
        send_frame(8'h3C, 434, 1'b1);
        idle(300);
        check_eq("t3_data", rx_data, 8'h3C);
        check_eq("t3_strobes", valid_cnt - v0, 1);

        // Framing error followed by a held break
        send_frame(8'h81, 434, 1'b1);
        idle(300);
        v0 = valid_cnt; e0 = err_cnt;
        send_frame(8'h7E, 434, 1'b0);
        uart_rxd = 1'b0;
        repeat (2000) @(negedge clk_50mhz);
        check_eq("t4_err_once", err_cnt - e0, 1);
        check_eq("t4_no_strobe", valid_cnt - v0, 0);
        check_eq("t4_data_held", rx_data, 8'h81);
        check_eq("t4_busy_in_break", rx_busy, 1'b1);
        idle(300);
        check_eq("t4_busy_after_break", rx_busy, 1'b0);
        check_eq("t4_err_still_once", err_cnt - e0, 1);
        check_eq("t4_no_false_start", valid_cnt - v0, 0);
        send_frame(8'h42, 434, 1'b1);
        idle(300);
        check_eq("t4_data", rx_data, 8'h42);
        check_eq("t4_strobes", valid_cnt - v0, 1);

        // Reset during bit 4; remaining bits are high so no new start follows
        v0 = valid_cnt; e0 = err_cnt;
        drive_bit(1'b0, 434);
        for (int i = 0; i < 4; i++)
            drive_bit(d5[i], 434);
        uart_rxd = 1'b1;
        repeat (20) @(negedge clk_50mhz);
        rst_n = 1'b0;
        repeat (10) @(negedge clk_50mhz);
        check_eq("t5_rst_data", rx_data, 8'h00);
        check_eq("t5_rst_busy", rx_busy, 1'b0);
        check_eq("t5_rst_valid", rx_valid, 1'b0);
        check_eq("t5_rst_err", rx_frame_err, 1'b0);
        rst_n = 1'b1;
        idle(434 * 5);
        check_eq("t5_no_strobe", valid_cnt - v0, 0);
        check_eq("t5_no_err", err_cnt - e0, 0);
        send_frame(8'h99, 434, 1'b1);
        idle(300);
        check_eq("t5_data", rx_data, 8'h99);
        check_eq("t5_strobes", valid_cnt - v0, 1);

        check_eq("never_both_strobes", both_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
